// File: rtl/pipeline_pkg.sv
// Opcode constants, scoreboard entry type and opcode-class helpers shared by
// the hazard controller and its scoreboard.
package pipeline_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Scoreboard rd field is sized for the widest supported register address.
   localparam int SB_RD_W = 8;

   typedef enum logic {
      BM_STALL      = 1'b0,
      BM_PREDICT_NT = 1'b1
   } branch_mode_e;

   typedef enum logic {
      ST_IDLE         = 1'b0,
      ST_WAIT_RESOLVE = 1'b1
   } ctrl_state_e;

   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               is_load;
      logic               is_ctrl;
   } sb_entry_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_JALR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OPC_STORE, OPC_OP, OPC_BRANCH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] op);
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI, OPC_JAL, OPC_JALR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_ctrl(input logic [6:0] op);
      case (op)
         OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input logic [6:0] op);
      return op == OPC_LOAD;
   endfunction

endpackage

// File: rtl/pipeline_scoreboard.sv
// In-flight destination tracker (entry 0 = EX) and RAW compare against decode.
// PIPELINE_FORWARDING_EN: only a load in entry 0 can cause a hazard.
module pipeline_scoreboard
   import pipeline_pkg::*;
#(
   parameter int WB_DISTANCE = 3,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  advance_i,
   input  logic                  push_i,
   input  logic [REG_ADDR_W-1:0] push_rd_i,
   input  logic                  push_load_i,
   input  logic                  push_ctrl_i,
   input  logic                  check_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic                  use_rs1_i,
   input  logic                  use_rs2_i,
   output logic                  hazard_o
);

   sb_entry_t sb_q [WB_DISTANCE];
   sb_entry_t push_entry;
   logic      hazard;

   // rd of x0 is recorded as zero, so it can never match below.
   function automatic logic hits(input sb_entry_t e);
      return e.valid && (e.rd != '0) &&
             ((use_rs1_i && (e.rd == SB_RD_W'(rs1_i))) ||
              (use_rs2_i && (e.rd == SB_RD_W'(rs2_i))));
   endfunction

   always_comb begin
      push_entry         = '0;
      push_entry.valid   = push_i;
      push_entry.rd      = push_i ? SB_RD_W'(push_rd_i) : '0;
      push_entry.is_load = push_i & push_load_i;
      push_entry.is_ctrl = push_i & push_ctrl_i;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < WB_DISTANCE; i++) begin
            sb_q[i] <= '0;
         end
      end else if (advance_i) begin
         sb_q[0] <= push_entry;
         for (int i = 1; i < WB_DISTANCE; i++) begin
            sb_q[i] <= sb_q[i-1];
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
`ifdef PIPELINE_FORWARDING_EN
      hazard = sb_q[0].is_load && hits(sb_q[0]);
`else
      for (int i = 0; i < WB_DISTANCE; i++) begin
         if (hits(sb_q[i])) begin
            hazard = 1'b1;
         end
      end
`endif
   end

   assign hazard_o = check_i & hazard;

endmodule

// File: rtl/pipeline_hazard_control.sv
// Decode-side pipeline controller: PC/IF-ID/ID-EX enables from RAW hazards,
// control-transfer policy (stall-until-resolve or predict-not-taken) and mem stalls.
module pipeline_hazard_control
   import pipeline_pkg::*;
#(
   parameter int WB_DISTANCE   = 3,
   parameter int REG_ADDR_W    = 5,
   parameter int BRANCH_MODE   = 0,
   parameter int RESOLVE_STAGE = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [6:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_resolve,
   input  logic                  ex_redirect,
   input  logic                  mem_stall,
   output logic                  pc_write_enable,
   output logic                  fetch_enable,
   output logic                  flush,
   output logic                  issue,
   output logic                  bubble,
   output logic                  raw_hazard,
   output logic                  ctrl_error
);

   localparam branch_mode_e MODE = (BRANCH_MODE == 1) ? BM_PREDICT_NT : BM_STALL;
   localparam int CNT_W = $clog2(WB_DISTANCE + 2) + 1;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(RESOLVE_STAGE + 1);

   ctrl_state_e           state_q;
   logic [CNT_W-1:0]      wait_cnt_q;
   logic                  ctrl_error_q;

   logic                  redirect;
   logic                  use_rs1;
   logic                  use_rs2;
   logic                  sb_hazard;
   logic [REG_ADDR_W-1:0] push_rd;

   logic                  pc_we_d;
   logic                  fetch_d;
   logic                  flush_d;
   logic                  issue_d;
   logic                  bubble_d;
   logic                  raw_d;

   // ex_redirect alone carries no meaning.
   assign redirect = ex_resolve & ex_redirect;
   assign use_rs1  = id_valid & uses_rs1(id_opcode);
   assign use_rs2  = id_valid & uses_rs2(id_opcode);
   assign push_rd  = writes_rd(id_opcode) ? id_rd : '0;

   pipeline_scoreboard #(
      .WB_DISTANCE (WB_DISTANCE),
      .REG_ADDR_W  (REG_ADDR_W)
   ) u_scoreboard (
      .clock       (clock),
      .reset       (reset),
      .advance_i   (!mem_stall),
      .push_i      (issue_d),
      .push_rd_i   (push_rd),
      .push_load_i (is_load(id_opcode)),
      .push_ctrl_i (is_ctrl(id_opcode)),
      .check_i     (id_valid),
      .rs1_i       (id_rs1),
      .rs2_i       (id_rs2),
      .use_rs1_i   (use_rs1),
      .use_rs2_i   (use_rs2),
      .hazard_o    (sb_hazard)
   );

   always_comb begin
      pc_we_d  = 1'b0;
      fetch_d  = 1'b0;
      flush_d  = 1'b0;
      issue_d  = 1'b0;
      bubble_d = 1'b0;
      raw_d    = 1'b0;
      if (reset) begin
         flush_d  = 1'b1;
         bubble_d = 1'b1;
      end else if (!mem_stall) begin
         if (redirect) begin
            // Kills whatever sits in decode, including a hazard-stalled instruction.
            pc_we_d  = 1'b1;
            fetch_d  = 1'b1;
            flush_d  = 1'b1;
            bubble_d = 1'b1;
         end else if (state_q == ST_WAIT_RESOLVE) begin
            bubble_d = 1'b1;
            if (ex_resolve) begin
               pc_we_d = 1'b1;
               fetch_d = 1'b1;
            end
         end else if (sb_hazard) begin
            bubble_d = 1'b1;
            raw_d    = 1'b1;
         end else begin
            pc_we_d  = 1'b1;
            fetch_d  = 1'b1;
            issue_d  = id_valid;
            bubble_d = !id_valid;
         end
      end
   end

   // Control-transfer FSM; a mem stall freezes state, counter and error.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         ctrl_error_q <= 1'b0;
      end else if (!mem_stall) begin
         if (redirect) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if ((MODE == BM_STALL) && issue_d && is_ctrl(id_opcode)) begin
                     state_q    <= ST_WAIT_RESOLVE;
                     wait_cnt_q <= '0;
                  end
               end
               ST_WAIT_RESOLVE: begin
                  if (ex_resolve) begin
                     state_q    <= ST_IDLE;
                     wait_cnt_q <= '0;
                  end else if (wait_cnt_q >= WAIT_LIMIT) begin
                     ctrl_error_q <= 1'b1;
                     state_q      <= ST_IDLE;
                     wait_cnt_q   <= '0;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  wait_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign pc_write_enable = pc_we_d;
   assign fetch_enable    = fetch_d;
   assign flush           = flush_d;
   assign issue           = issue_d;
   assign bubble          = bubble_d;
   assign raw_hazard      = raw_d;
   assign ctrl_error      = ctrl_error_q;

endmodule
